// File: rtl/trivium_pkg.sv
// Shared constants and types for the Trivium keystream generator and its consumers.
package trivium_pkg;
    localparam int BLK_W  = 512;
    localparam int NBYTES = BLK_W / 8;
    localparam int IDX_W  = $clog2(NBYTES);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef logic [IDX_W-1:0] byte_idx_t;
endpackage

// File: rtl/trivium_byte_sel.sv
// Combinational keystream byte picker; byte 0 is the most significant byte of the block.
module trivium_byte_sel
    import trivium_pkg::*;
(
    input  logic [BLK_W-1:0] blk,
    input  byte_idx_t        idx,
    output logic [7:0]       byte_out
);

    always_comb begin
        byte_out = blk[BLK_W-1-8*idx -: 8];
    end

endmodule

// File: rtl/trivium_stream_xor.sv
// Holds one keystream block and XORs it byte-by-byte onto a plaintext stream.
//
// state | meaning
// EMPTY | no usable keystream; accepting a new block, plaintext stalled
// FULL  | block held; plaintext bytes consumed from byte ptr upward
module trivium_stream_xor
    import trivium_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BLK_W-1:0] ks_data,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [7:0]       pt_data,
    input  logic             pt_last,
    input  logic             pt_valid,
    output logic             pt_ready,
    output logic [7:0]       ct_data,
    output logic             ct_last,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic [15:0]      msg_bytes
);

    state_t           state;
    state_t           state_nxt;
    logic [BLK_W-1:0] ks_buf;
    byte_idx_t        ptr;
    logic [7:0]       ks_byte;
    logic             last_seen;
    logic             ks_fire;
    logic             pt_fire;
    logic             ct_fire;
    logic             blk_done;

    trivium_byte_sel u_byte_sel (
        .blk      (ks_buf),
        .idx      (ptr),
        .byte_out (ks_byte)
    );

    assign ks_fire  = ks_valid && ks_ready;
    assign pt_fire  = pt_valid && pt_ready;
    assign ct_fire  = ct_valid && ct_ready;
    // A message never continues into the tail of a block, so pt_last retires it too.
    assign blk_done = pt_fire && (pt_last || (ptr == byte_idx_t'(NBYTES - 1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ks_ready  = 1'b0;
        pt_ready  = 1'b0;
        case (state)
            EMPTY: begin
                ks_ready = 1'b1;
                if (ks_valid) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                pt_ready = !ct_valid || ct_ready;
                if (blk_done) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ks_buf    <= '0;
            ptr       <= '0;
            ct_data   <= 8'h00;
            ct_last   <= 1'b0;
            ct_valid  <= 1'b0;
            msg_bytes <= 16'h0000;
            last_seen <= 1'b0;
        end else begin
            if (ks_fire) begin
                ks_buf <= ks_data;
                ptr    <= '0;
            end else if (pt_fire && !blk_done) begin
                ptr <= ptr + 1'b1;
            end

            if (pt_fire) begin
                ct_data   <= pt_data ^ ks_byte;
                ct_last   <= pt_last;
                ct_valid  <= 1'b1;
                msg_bytes <= last_seen ? 16'd1 : msg_bytes + 16'd1;
                last_seen <= pt_last;
            end else if (ct_fire) begin
                ct_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Bench for trivium_stream_xor: directed scenarios plus randomized messages against a byte-level model.
module tb_trivium_stream_xor;
    import trivium_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [BLK_W-1:0] ks_data;
    logic             ks_valid;
    logic             ks_ready;
    logic [7:0]       pt_data;
    logic             pt_last;
    logic             pt_valid;
    logic             pt_ready;
    logic [7:0]       ct_data;
    logic             ct_last;
    logic             ct_valid;
    logic             ct_ready;
    logic [15:0]      msg_bytes;

    always #5 clk = ~clk;

    trivium_stream_xor dut (
        .clk       (clk),
        .reset     (reset),
        .ks_data   (ks_data),
        .ks_valid  (ks_valid),
        .ks_ready  (ks_ready),
        .pt_data   (pt_data),
        .pt_last   (pt_last),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .ct_data   (ct_data),
        .ct_last   (ct_last),
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .msg_bytes (msg_bytes)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: ordered list of keystream blocks, messages mapped onto whole blocks.
    logic [BLK_W-1:0] blks[$];
    logic [7:0]       pt_arr[$];
    logic [8:0]       exp_q[$];
    logic [7:0]       got_q[$];
    int               ks_idx, blk_base, msg_len, pi, stop_at;
    int               ks_stall, bp_start, bp_left, bubbles, stall_rdy;
    bit               have_blk, pend, prev_last, hold_chk, held_last, rnd_mode;
    logic [7:0]       held_data;
    logic [15:0]      exp_msg;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] rand_blk();
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BLK_W / 32; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [7:0] ks_byte_of(input int msg_pos);
        logic [BLK_W-1:0] b;
        int bi;
        bi = blk_base + msg_pos / NBYTES;
        b  = (bi < blks.size()) ? blks[bi] : '0;
        b  = b >> (8 * (NBYTES - 1 - msg_pos % NBYTES));
        return b[7:0];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend      = 0;
        have_blk  = 0;
        prev_last = 0;
        hold_chk  = 0;
        exp_msg   = 16'd0;
        blk_base  = ks_idx;
    endtask

    task automatic step();
        bit exp_prdy, retire, acc, kacc, in_stall;
        logic [8:0] e;
        @(negedge clk);
        chk("ct_valid", 16'(ct_valid), 16'(pend));
        chk("ks_ready", 16'(ks_ready), 16'(!have_blk));
        chk("msg_bytes", msg_bytes, exp_msg);
        if (hold_chk) begin
            chk("hold_data", 16'(ct_data), 16'(held_data));
            chk("hold_last", 16'(ct_last), 16'(held_last));
        end
        if (bp_start >= 0 && pi == bp_start && pend) begin
            bp_left  = 5;
            bp_start = -1;
        end
        if (bp_left > 0) begin
            ct_ready = 1'b0;
            bp_left--;
        end else begin
            ct_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        in_stall = (ks_stall > 0);
        if (in_stall) begin
            ks_valid = 1'b0;
            ks_stall--;
        end else begin
            ks_valid = (ks_idx < blks.size()) && (!rnd_mode || $urandom_range(0, 3) != 0);
        end
        ks_data  = (ks_idx < blks.size()) ? blks[ks_idx] : '0;
        pt_valid = (pi < stop_at) && (!rnd_mode || $urandom_range(0, 3) != 0);
        pt_data  = (pi < msg_len) ? pt_arr[pi] : 8'h00;
        pt_last  = (pi == msg_len - 1);
        #1;
        exp_prdy = have_blk && (!pend || ct_ready);
        chk("pt_ready", 16'(pt_ready), 16'(exp_prdy));
        if (in_stall) stall_rdy += int'(pt_ready) + int'(ct_valid);
        if (pt_valid && !exp_prdy && pi > 0) bubbles++;
        retire = pend && ct_ready;
        acc    = pt_valid && exp_prdy;
        kacc   = ks_valid && !have_blk;
        if (retire) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1xx;
            chk("ct_data", 16'(ct_data), 16'(e[7:0]));
            chk("ct_last", 16'(ct_last), 16'(e[8]));
            got_q.push_back(ct_data);
        end
        hold_chk  = pend && !ct_ready;
        held_data = ct_data;
        held_last = ct_last;
        if (acc) begin
            exp_q.push_back({pt_last, pt_data ^ ks_byte_of(pi)});
            exp_msg   = prev_last ? 16'd1 : exp_msg + 16'd1;
            prev_last = pt_last;
            if (pt_last || pi % NBYTES == NBYTES - 1) have_blk = 0;
            pi++;
        end
        pend = acc || (pend && !ct_ready);
        if (kacc) begin
            have_blk = 1;
            ks_idx++;
        end
    endtask

    task automatic run_msg(input int len, input int stop, input bit fill_rand);
        int budget;
        int need;
        if (fill_rand) begin
            pt_arr.delete();
            for (int i = 0; i < len; i++) pt_arr.push_back(8'($urandom));
        end
        need = blk_base + (len + NBYTES - 1) / NBYTES;
        while (blks.size() < need) blks.push_back(rand_blk());
        msg_len = len;
        stop_at = stop;
        pi      = 0;
        bubbles = 0;
        got_q.delete();
        budget  = 0;
        while (!(pi >= stop && (stop < len || (!pend && exp_q.size() == 0))) && budget < 3000) begin
            step();
            budget++;
        end
        chk("msg_budget", 16'(budget < 3000), 16'd1);
        if (stop == len) blk_base += (len + NBYTES - 1) / NBYTES;
    endtask

    initial begin
        logic [BLK_W-1:0] tmp_blk;
        int len;
        reset    = 1'b1;
        ks_valid = 1'b0;
        ks_data  = '0;
        pt_valid = 1'b0;
        pt_data  = 8'h00;
        pt_last  = 1'b0;
        ct_ready = 1'b0;
        ks_idx   = 0;
        ks_stall = 0;
        bp_start = -1;
        bp_left  = 0;
        rnd_mode = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ct_valid", 16'(ct_valid), 16'd0);
        chk("rst_ct_data", 16'(ct_data), 16'd0);
        chk("rst_ct_last", 16'(ct_last), 16'd0);
        chk("rst_msg_bytes", msg_bytes, 16'd0);
        chk("rst_ks_ready", 16'(ks_ready), 16'd1);
        chk("rst_pt_ready", 16'(pt_ready), 16'd0);
        reset = 1'b0;

        // Byte ordering: MSB byte first.
        blks.push_back({8'h12, 8'h34, 496'h0});
        pt_arr = '{8'h00, 8'hFF};
        run_msg(2, 2, 0);
        chk("order_b0", 16'(got_q[0]), 16'h0012);
        chk("order_b1", 16'(got_q[1]), 16'h00CB);

        // Full block then a second block, one bubble at the boundary.
        blks.push_back({NBYTES{8'hFF}});
        blks.push_back({NBYTES{8'h0F}});
        pt_arr.delete();
        for (int i = 0; i < 65; i++) pt_arr.push_back(8'h00);
        run_msg(65, 65, 0);
        chk("wrap_b63", 16'(got_q[63]), 16'h00FF);
        chk("wrap_b64", 16'(got_q[64]), 16'h000F);
        chk("wrap_bubbles", 16'(bubbles), 16'd1);
        chk("wrap_count", msg_bytes, 16'd65);
        chk("wrap_len", 16'(got_q.size()), 16'd65);

        // Early last discards the rest of the block.
        blks.push_back(rand_blk());
        blks.push_back(rand_blk());
        run_msg(4, 4, 1);
        chk("early_count", msg_bytes, 16'd4);
        tmp_blk = blks[blk_base];
        run_msg(3, 3, 1);
        chk("early_next_b0", 16'(got_q[0]), 16'(pt_arr[0] ^ tmp_blk[BLK_W-1 -: 8]));
        chk("early_next_count", msg_bytes, 16'd3);

        // Backpressure mid-stream.
        bp_start = 20;
        run_msg(40, 40, 1);
        chk("bp_len", 16'(got_q.size()), 16'd40);

        // Reset after 10 accepted bytes.
        run_msg(20, 10, 1);
        @(negedge clk);
        reset    = 1'b1;
        pt_valid = 1'b0;
        ks_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_ct_valid", 16'(ct_valid), 16'd0);
        chk("mid_rst_ks_ready", 16'(ks_ready), 16'd1);
        chk("mid_rst_msg_bytes", msg_bytes, 16'd0);
        reset = 1'b0;
        run_msg(5, 5, 1);
        chk("post_rst_len", 16'(got_q.size()), 16'd5);

        // Generator stall.
        ks_stall  = 20;
        stall_rdy = 0;
        run_msg(3, 3, 1);
        chk("stall_quiet", 16'(stall_rdy), 16'd0);

        // Randomized messages with random gaps, stalls and backpressure.
        rnd_mode = 1;
        for (int m = 0; m < 8; m++) begin
            len = $urandom_range(1, 150);
            ks_stall = $urandom_range(0, 6);
            run_msg(len, len, 1);
            chk("rnd_len", 16'(got_q.size()), 16'(len));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/trivium_stream_xor.md
# trivium_stream_xor

Downstream consumer of the Trivium keystream generator: accepts 512-bit keystream blocks, holds one block, and XORs it byte-by-byte with an incoming plaintext byte stream to produce ciphertext bytes. It sits between the generator's block output and the link/packet layer. Decryption uses the same datapath. All three ports use valid/ready handshakes, so the generator can be stalled and output backpressure is honoured.

## Interface
- BLK_W, 512, keystream block width in bits; must be a multiple of 8.
- NBYTES, BLK_W/8 (64), bytes per block; derived, not overridable.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ks_data  in  BLK_W  keystream block; byte 0 = ks_data[BLK_W-1 -: 8] (first generated bit is MSB).
- ks_valid  in  1  keystream block available.
- ks_ready  out  1  block buffer empty, will accept.
- pt_data  in  8  plaintext byte.
- pt_last  in  1  final byte of message.
- pt_valid  in  1  plaintext byte valid.
- pt_ready  out  1  plaintext byte accepted this cycle if valid.
- ct_data  out  8  ciphertext byte.
- ct_last  out  1  copy of pt_last for this byte.
- ct_valid  out  1  ciphertext byte valid.
- ct_ready  in  1  downstream accepts.
- msg_bytes  out  16  bytes of current/last message emitted; wraps at 2^16.

## Operation
- State machine with two states:
  - EMPTY (reset state): ks_ready=1, pt_ready=0. On ks_valid&ks_ready, register ks_data into buf, ptr<=0, go to FULL.
  - FULL: ks_ready=0; pt_ready = !ct_valid | ct_ready.
- On pt handshake in FULL:
  - ct_data <= pt_data ^ buf[BLK_W-1-8*ptr -: 8].
  - ct_last <= pt_last; ct_valid <= 1.
  - ptr <= ptr+1.
  - msg_bytes <= msg_bytes+1, or 1 if the previous accepted byte had pt_last.
- Exit FULL to EMPTY when a byte is accepted and either ptr==NBYTES-1 or pt_last=1. On pt_last, unused keystream is discarded; every message starts at byte 0 of a fresh block.
- ct_valid clears on ct_valid&ct_ready when no new byte is accepted that cycle. Accept and retire in the same cycle is allowed (full throughput).
- While ct_valid=1 and ct_ready=0, ct_data, ct_last and ct_valid hold stable.
- A block load (EMPTY) may coincide with a pending ct byte being held or retired; these are independent.
- Reset values: ct_valid=0, ct_data=0, ct_last=0, msg_bytes=0, buf=0, ptr=0, state EMPTY.
- Reset asserted mid-message drops the buffered block and any pending ct byte. No partial output after reset deassertion.

## Timing
- Latency: pt handshake at cycle N gives ct_valid at cycle N+1.
- Throughput: 1 byte/cycle within a block.
- One bubble cycle per block boundary: the EMPTY cycle that loads the next block, with pt_ready=0.
- ks_ready is a registered function of state only. It never depends combinationally on ks_valid.
- pt_ready depends combinationally on ct_ready. No other input-to-output combinational paths.
- ptr is $clog2(NBYTES) bits wide; it never wraps, because the state exits at NBYTES-1.

## Structure
- Shared package trivium_pkg:
  - BLK_W and NBYTES constants.
  - state enum {EMPTY, FULL}.
  - byte-index type sized $clog2(NBYTES). The generator uses the same BLK_W.
- One sub-module: trivium_byte_sel, a combinational BLK_W-to-8 mux indexed by ptr, reused by the generator's self-check bench.

## Test plan
- Byte ordering: ks_data[511:504]=8'h12, [503:496]=8'h34, rest 0; pt 8'h00, 8'hFF → ct 8'h12, 8'hCB.
- Full block then wrap: ks all 8'hFF then all 8'h0F; 65-byte message pt=8'h00 → bytes 0..63 = 8'hFF, byte 64 = 8'h0F; exactly one pt_ready=0 bubble at byte 64; msg_bytes=65.
- Early last: pt_last on byte 3 → ct_last on byte 3, state EMPTY. Next message's byte 0 uses byte 0 of the next block, and msg_bytes restarts at 1.
- Backpressure: ct_ready=0 for 5 cycles mid-stream → ct_data stable, pt_ready=0 after the first held byte, no loss or duplication when ct_ready returns to 1.
- Reset mid-message: assert reset after 10 bytes → ct_valid=0, ks_ready=1, msg_bytes=0 on the next clock. A new block plus pt gives correct ct from byte 0.
- Generator stall: ks_valid held 0 for 20 cycles in EMPTY → pt_ready stays 0 and no ct_valid.
